// File: rtl/tr_light_monitor.sv
// Passive light-bus monitor: rebuilds the intersection phase from the EW/NS codes,
// checks order, dwell and safety, and reports sticky faults plus completed cycles.
module tr_light_monitor #(
    parameter int GREEN_CYC  = 6,
    parameter int YEL_CYC    = 2,
    parameter int ALLRED_CYC = 2,
    parameter int DW_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ew_lights,
    input  logic [1:0] ns_lights,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic       locked,
    output logic       err_conflict,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_time,
    output logic       fault,
    output logic [7:0] cycle_cnt
);
    localparam logic [1:0]      RED    = 2'b00;
    localparam logic [1:0]      YEL    = 2'b01;
    localparam logic [1:0]      GRN    = 2'b10;
    localparam logic [1:0]      BAD    = 2'b11;
    localparam logic [DW_W-1:0] DW_MAX = '1;

    typedef enum logic {S_ACQUIRE, S_LOCKED} state_t;

    state_t          r_state, w_state;
    logic [2:0]      r_phase, w_phase;
    logic [DW_W-1:0] r_dwell, w_dwell;
    logic            r_first, w_first;
    logic [1:0]      r_last_ew, r_last_ns;
    logic            r_err_conflict, w_err_conflict;
    logic            r_err_code, w_err_code;
    logic            r_err_seq, w_err_seq;
    logic            r_err_time, w_err_time;
    logic            r_fault, w_fault;
    logic [7:0]      r_cycle_cnt, w_cycle_cnt;

    logic            w_change;
    logic            w_dec_ok;
    logic [2:0]      w_dec;
    logic [2:0]      w_succ;
    logic [DW_W-1:0] w_expect;

    // Decode the new observation; all-red is told apart by which yellow preceded it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_dec_ok = 1'b1;
        w_dec    = 3'd0;
        case ({ns_lights, ew_lights})
            {GRN, RED}: w_dec = 3'd0;
            {YEL, RED}: w_dec = 3'd1;
            {RED, GRN}: w_dec = 3'd3;
            {RED, YEL}: w_dec = 3'd4;
            {RED, RED}: begin
                if (r_last_ns == YEL)      w_dec = 3'd2;
                else if (r_last_ew == YEL) w_dec = 3'd5;
                else                       w_dec_ok = 1'b0;
            end
            default:    w_dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (r_phase)
            3'd0, 3'd3: w_expect = DW_W'(GREEN_CYC);
            3'd1, 3'd4: w_expect = DW_W'(YEL_CYC);
            default:    w_expect = DW_W'(ALLRED_CYC);
        endcase
    end

    assign w_change = {ew_lights, ns_lights} != {r_last_ew, r_last_ns};
    assign w_succ   = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;

    always_comb begin
        w_state        = r_state;
        w_phase        = r_phase;
        w_dwell        = r_dwell;
        w_first        = r_first;
        w_cycle_cnt    = r_cycle_cnt;
        w_err_seq      = r_err_seq;
        w_err_time     = r_err_time;
        w_err_code     = r_err_code | (ew_lights == BAD) | (ns_lights == BAD);
        w_err_conflict = r_err_conflict | ((ew_lights != RED) && (ns_lights != RED));

        case (r_state)
            S_ACQUIRE: begin
                if (w_change && w_dec_ok) begin
                    w_state = S_LOCKED;
                    w_phase = w_dec;
                    w_dwell = DW_W'(1);
                    w_first = 1'b1;
                end
            end
            default: begin
                if (!w_change) begin
                    if (!r_first && r_dwell == w_expect) w_err_time = 1'b1;
                    if (r_dwell != DW_MAX)               w_dwell    = r_dwell + DW_W'(1);
                end else begin
                    if (!r_first && r_dwell != w_expect) w_err_time = 1'b1;
                    if (!w_dec_ok || w_dec != w_succ) begin
                        w_err_seq = 1'b1;
                        w_state   = S_ACQUIRE;
                    end else begin
                        if (r_phase == 3'd5) w_cycle_cnt = r_cycle_cnt + 8'd1;
                        w_phase = w_succ;
                        w_dwell = DW_W'(1);
                        w_first = 1'b0;
                    end
                end
            end
        endcase

        // Clearing re-acquires from scratch and overrides anything detected this cycle.
        if (clr_err) begin
            w_state        = S_ACQUIRE;
            w_cycle_cnt    = r_cycle_cnt;
            w_err_conflict = 1'b0;
            w_err_code     = 1'b0;
            w_err_seq      = 1'b0;
            w_err_time     = 1'b0;
        end

        w_fault = w_err_conflict | w_err_code | w_err_seq | w_err_time;
    end

    // NOTE: synchronous active-low reset sits inside the clocked block, so it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_ACQUIRE;
            r_phase        <= 3'd0;
            r_dwell        <= '0;
            r_first        <= 1'b0;
            r_last_ew      <= RED;
            r_last_ns      <= RED;
            r_err_conflict <= 1'b0;
            r_err_code     <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_time     <= 1'b0;
            r_fault        <= 1'b0;
            r_cycle_cnt    <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state        <= w_state;
            r_phase        <= w_phase;
            r_dwell        <= w_dwell;
            r_first        <= w_first;
            r_last_ew      <= ew_lights;
            r_last_ns      <= ns_lights;
            r_err_conflict <= w_err_conflict;
            r_err_code     <= w_err_code;
            r_err_seq      <= w_err_seq;
            r_err_time     <= w_err_time;
            r_fault        <= w_fault;
            r_cycle_cnt    <= w_cycle_cnt;
        end
    end

    assign phase        = r_phase;
    assign locked       = (r_state == S_LOCKED);
    assign err_conflict = r_err_conflict;
    assign err_code     = r_err_code;
    assign err_seq      = r_err_seq;
    assign err_time     = r_err_time;
    assign fault        = r_fault;
    assign cycle_cnt    = r_cycle_cnt;
endmodule
